// File: rtl/pixel_process_pkg.sv
// Shared pixel-pipe constants: mode encodings, x256 YCbCr coefficients and the default skin window.
// No logic, no latency, no flow control of its own.
package pixel_process_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_SKIN = 2'd2,
        MODE_INV  = 2'd3
    } mode_e;

    localparam int C_YR  = 77;
    localparam int C_YG  = 150;
    localparam int C_YB  = 29;
    localparam int C_CBR = -43;
    localparam int C_CBG = -85;
    localparam int C_CBB = 128;
    localparam int C_CRR = 128;
    localparam int C_CRG = -107;
    localparam int C_CRB = -21;
    localparam int RND   = 128;

    localparam int DEF_CB_MIN = 76;
    localparam int DEF_CB_MAX = 128;
    localparam int DEF_CR_MIN = 132;
    localparam int DEF_CR_MAX = 174;

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/rgb2ycbcr_pipe.sv
// RGB -> Y plus skin-window flag in two registered stages (products, then sum/scale/clamp/compare).
// Both stages advance only on i_en; with i_en low every register holds.
module rgb2ycbcr_pipe
    import pixel_process_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_r,
    input  logic [DATA_W-1:0] i_g,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_cb_min,
    input  logic [DATA_W-1:0] i_cb_max,
    input  logic [DATA_W-1:0] i_cr_min,
    input  logic [DATA_W-1:0] i_cr_max,
    output logic [DATA_W-1:0] o_y,
    output logic              o_skin
);

    localparam int PW   = DATA_W + 10;
    localparam int OFF  = 1 << (DATA_W + 7);
    localparam int MAXV = (1 << DATA_W) - 1;

    logic signed [PW-1:0] r_p [9];
    logic [DATA_W-1:0]    w_y;
    logic [DATA_W-1:0]    w_cb;
    logic [DATA_W-1:0]    w_cr;
    logic                 w_skin;

    function automatic logic signed [PW-1:0] mul(input int c, input logic [DATA_W-1:0] x);
        return PW'(c * int'(x));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_p[i] <= '0;
        end else if (i_en) begin
            r_p[0] <= mul(C_YR,  i_r);
            r_p[1] <= mul(C_YG,  i_g);
            r_p[2] <= mul(C_YB,  i_b);
            r_p[3] <= mul(C_CBR, i_r);
            r_p[4] <= mul(C_CBG, i_g);
            r_p[5] <= mul(C_CBB, i_b);
            r_p[6] <= mul(C_CRR, i_r);
            r_p[7] <= mul(C_CRG, i_g);
            r_p[8] <= mul(C_CRB, i_b);
        end
    end

    // Chroma is offset to mid-scale before the shift so the clamp only ever trims the top end.
    always_comb begin
        w_y  = DATA_W'(clamp((int'(r_p[0]) + int'(r_p[1]) + int'(r_p[2]) + RND) >>> 8, MAXV));
        w_cb = DATA_W'(clamp((int'(r_p[3]) + int'(r_p[4]) + int'(r_p[5]) + OFF + RND) >>> 8, MAXV));
        w_cr = DATA_W'(clamp((int'(r_p[6]) + int'(r_p[7]) + int'(r_p[8]) + OFF + RND) >>> 8, MAXV));
        w_skin = (w_cb > i_cb_min) && (w_cb < i_cb_max) &&
                 (w_cr > i_cr_min) && (w_cr < i_cr_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_y    <= '0;
            o_skin <= 1'b0;
        end else if (i_en) begin
            o_y    <= w_y;
            o_skin <= w_skin;
        end
    end

endmodule

// File: rtl/pixel_process_pipe.sv
// Streaming RGB pixel processor (pass/gray/skin-mask/invert) plus per-frame skin count; 3-cycle latency.
// Single global enable: the whole pipe stalls when m_valid && !m_ready, and s_ready drops with it.
module pixel_process_pipe
    import pixel_process_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 20,
    parameter int CB_MIN_DEF = DEF_CB_MIN,
    parameter int CB_MAX_DEF = DEF_CB_MAX,
    parameter int CR_MIN_DEF = DEF_CR_MIN,
    parameter int CR_MAX_DEF = DEF_CR_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              thr_we,
    input  logic [DATA_W-1:0] thr_cb_min,
    input  logic [DATA_W-1:0] thr_cb_max,
    input  logic [DATA_W-1:0] thr_cr_min,
    input  logic [DATA_W-1:0] thr_cr_max,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_r,
    input  logic [DATA_W-1:0] s_g,
    input  logic [DATA_W-1:0] s_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic [DATA_W-1:0] m_r,
    output logic [DATA_W-1:0] m_g,
    output logic [DATA_W-1:0] m_b,
    output logic [CNT_W-1:0]  skin_cnt
);

    logic [DATA_W-1:0]   r_thr_cb_min, r_thr_cb_max, r_thr_cr_min, r_thr_cr_max;
    logic                r_v1, r_v2, r_sof1, r_sof2, r_white;
    mode_e               r_mode1, r_mode2;
    logic [3*DATA_W-1:0] r_rgb1, r_rgb2;
    logic [CNT_W-1:0]    r_run;
    logic                w_en, w_skin;
    logic [DATA_W-1:0]   w_y;
    logic [3*DATA_W-1:0] w_out;

    assign w_en    = !m_valid || m_ready;
    assign s_ready = w_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr_cb_min <= DATA_W'(CB_MIN_DEF);
            r_thr_cb_max <= DATA_W'(CB_MAX_DEF);
            r_thr_cr_min <= DATA_W'(CR_MIN_DEF);
            r_thr_cr_max <= DATA_W'(CR_MAX_DEF);
        end else if (thr_we) begin
            r_thr_cb_min <= thr_cb_min;
            r_thr_cb_max <= thr_cb_max;
            r_thr_cr_min <= thr_cr_min;
            r_thr_cr_max <= thr_cr_max;
        end
    end

    rgb2ycbcr_pipe #(.DATA_W(DATA_W)) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_en),
        .i_r      (s_r),
        .i_g      (s_g),
        .i_b      (s_b),
        .i_cb_min (r_thr_cb_min),
        .i_cb_max (r_thr_cb_max),
        .i_cr_min (r_thr_cr_min),
        .i_cr_max (r_thr_cr_max),
        .o_y      (w_y),
        .o_skin   (w_skin)
    );

    // Sideband (valid, sof, mode, raw RGB) shadows the converter's two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_sof1  <= 1'b0;
            r_sof2  <= 1'b0;
            r_mode1 <= MODE_PASS;
            r_mode2 <= MODE_PASS;
            r_rgb1  <= '0;
            r_rgb2  <= '0;
        end else if (w_en) begin
            r_v1    <= s_valid;
            r_sof1  <= s_valid && s_sof;
            r_mode1 <= mode_e'(mode);
            r_rgb1  <= {s_r, s_g, s_b};
            r_v2    <= r_v1;
            r_sof2  <= r_sof1;
            r_mode2 <= r_mode1;
            r_rgb2  <= r_rgb1;
        end
    end

    always_comb begin
        w_out = r_rgb2;
        case (r_mode2)
            MODE_GRAY: w_out = {3{w_y}};
            MODE_SKIN: w_out = {(3*DATA_W){w_skin}};
            MODE_INV:  w_out = ~r_rgb2;
            default:   w_out = r_rgb2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_r     <= '0;
            m_g     <= '0;
            m_b     <= '0;
            r_white <= 1'b0;
        end else if (w_en) begin
            m_valid         <= r_v2;
            m_sof           <= r_sof2;
            {m_r, m_g, m_b} <= w_out;
            r_white         <= r_v2 && (r_mode2 == MODE_SKIN) && w_skin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skin_cnt <= '0;
            r_run    <= '0;
        end else if (m_valid && m_ready) begin
            if (m_sof) begin
                skin_cnt <= r_run;
                r_run    <= {{(CNT_W-1){1'b0}}, r_white};
            end else if (r_white && (r_run != '1)) begin
                r_run <= r_run + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pixel_process_pipe.sv
// Self-checking bench for pixel_process_pipe: directed single pixels plus scoreboarded streams.
module tb_pixel_process_pipe;

    localparam int DW = 8;
    localparam int CW = 20;
    localparam int PW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          thr_we = 1'b0;
    logic [DW-1:0] thr_cb_min = 8'd76, thr_cb_max = 8'd128, thr_cr_min = 8'd132, thr_cr_max = 8'd174;
    logic          s_valid = 1'b0, s_sof = 1'b0, s_ready;
    logic [DW-1:0] s_r = '0, s_g = '0, s_b = '0;
    logic          m_valid, m_sof;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_r, m_g, m_b;
    logic [CW-1:0] skin_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int t_cbmin = 76, t_cbmax = 128, t_crmin = 132, t_crmax = 174;
    logic [PW:0] sb[$];

    pixel_process_pipe dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .thr_we(thr_we),
        .thr_cb_min(thr_cb_min), .thr_cb_max(thr_cb_max),
        .thr_cr_min(thr_cr_min), .thr_cr_max(thr_cr_max),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
        .m_r(m_r), .m_g(m_g), .m_b(m_b), .skin_cnt(skin_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] model(input logic [1:0] md, input int r, input int g, input int b);
        int y, cb, cr;
        logic wh;
        y  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
        cb = (-43 * r - 85 * g + 128 * b + 32768 + 128) >>> 8;
        cr = (128 * r - 107 * g - 21 * b + 32768 + 128) >>> 8;
        if (y > 255) y = 255;
        if (cb > 255) cb = 255;
        if (cb < 0) cb = 0;
        if (cr > 255) cr = 255;
        if (cr < 0) cr = 0;
        wh = (cb > t_cbmin) && (cb < t_cbmax) && (cr > t_crmin) && (cr < t_crmax);
        case (md)
            2'd0:    return {DW'(r), DW'(g), DW'(b)};
            2'd1:    return {3{DW'(y)}};
            2'd2:    return {PW{wh}};
            default: return ~{DW'(r), DW'(g), DW'(b)};
        endcase
    endfunction

    task automatic drive(input logic v, input logic sof, input int md, input int r, input int g, input int b);
        s_valid = v;
        s_sof   = sof;
        mode    = 2'(md);
        s_r     = DW'(r);
        s_g     = DW'(g);
        s_b     = DW'(b);
    endtask

    // Presents one pixel to an idle pipe and reports the first output and its cycle offset (-1 if none).
    task automatic send_one(input int md, input int r, input int g, input int b,
                            output logic [PW-1:0] got, output int lat);
        m_ready = 1'b1;
        drive(1'b1, 1'b0, md, r, g, b);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        lat = -1;
        got = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (m_valid) begin
                lat = c;
                got = {m_r, m_g, m_b};
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m_ready = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
        n_chk++; if ({m_sof, m_r, m_g, m_b} !== 25'd0) $display("FAIL reset_outputs got %h want 0", {m_sof, m_r, m_g, m_b}); else n_pass++;
        n_chk++; if (skin_cnt !== 20'd0) $display("FAIL reset_skin_cnt got %0d want 0", skin_cnt); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL idle_m_valid got %b want 0", m_valid); else n_pass++;
    endtask

    task automatic test_pass;
        logic [PW-1:0] got;
        int lat;
        send_one(0, 10, 20, 30, got, lat);
        n_chk++; if (lat != 3) $display("FAIL pass_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (got !== {8'd10, 8'd20, 8'd30}) $display("FAIL pass_data got %h want 0a141e", got); else n_pass++;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL pass_s_ready got %b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_gray;
        logic [PW-1:0] got;
        int lat;
        send_one(1, 100, 150, 200, got, lat);
        n_chk++; if (lat != 3 || got !== {3{8'd141}}) $display("FAIL gray_mid got %h lat %0d want 8d8d8d lat 3", got, lat); else n_pass++;
        send_one(1, 255, 255, 255, got, lat);
        n_chk++; if (lat != 3 || got !== {3{8'd255}}) $display("FAIL gray_white got %h lat %0d want ffffff lat 3", got, lat); else n_pass++;
    endtask

    task automatic test_skin;
        logic [PW-1:0] got;
        int lat;
        send_one(2, 200, 150, 120, got, lat);
        n_chk++; if (lat != 3 || got !== {3{8'd255}}) $display("FAIL skin_in got %h lat %0d want ffffff lat 3", got, lat); else n_pass++;
        send_one(2, 0, 0, 255, got, lat);
        n_chk++; if (lat != 3 || got !== 24'd0) $display("FAIL skin_cb_clamp got %h lat %0d want 000000 lat 3", got, lat); else n_pass++;
        thr_cb_max = 8'd100;
        t_cbmax = 100;
        thr_we = 1'b1;
        @(posedge clk); #1;
        thr_we = 1'b0;
        send_one(2, 200, 150, 120, got, lat);
        n_chk++; if (lat != 3 || got !== 24'd0) $display("FAIL skin_new_thr got %h lat %0d want 000000 lat 3", got, lat); else n_pass++;
        thr_cb_max = 8'd128;
        t_cbmax = 128;
        thr_we = 1'b1;
        @(posedge clk); #1;
        thr_we = 1'b0;
    endtask

    task automatic test_invert;
        logic [PW-1:0] got;
        int lat;
        send_one(3, 10, 20, 30, got, lat);
        n_chk++; if (lat != 3 || got !== {8'd245, 8'd235, 8'd225}) $display("FAIL invert got %h lat %0d want f5ebe1 lat 3", got, lat); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int md[12], pr[12], pg[12], pb[12];
        int sent = 0, outs = 0, cyc = 0;
        logic [PW:0] exp;
        for (int i = 0; i < 12; i++) begin
            md[i] = i % 4;
            pr[i] = $urandom_range(0, 255);
            pg[i] = $urandom_range(0, 255);
            pb[i] = $urandom_range(0, 255);
        end
        pr[2] = 200; pg[2] = 150; pb[2] = 120;
        m_ready = 1'b1;
        while ((sent < 12 || sb.size() != 0) && cyc < 100) begin
            if (sent < 12) drive(1'b1, sent == 0, md[sent], pr[sent], pg[sent], pb[sent]);
            else drive(1'b0, 1'b0, 0, 0, 0, 0);
            @(negedge clk);
            if (m_valid && m_ready) begin
                n_chk++;
                outs++;
                if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
                if ({m_sof, m_r, m_g, m_b} !== exp) $display("FAIL b2b_pixel got %h want %h", {m_sof, m_r, m_g, m_b}, exp);
                else n_pass++;
            end
            if (s_valid && s_ready) begin
                sb.push_back({s_sof, model(mode, s_r, s_g, s_b)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_chk++; if (outs != 12) $display("FAIL b2b_count got %0d want 12", outs); else n_pass++;
    endtask

    task automatic test_backpressure;
        int md[8], pr[8], pg[8], pb[8];
        int sent = 0, outs = 0, cyc = 0;
        logic [PW:0] exp;
        logic [PW+1:0] hold = '0;
        for (int i = 0; i < 8; i++) begin
            md[i] = (i * 3) % 4;
            pr[i] = $urandom_range(0, 255);
            pg[i] = $urandom_range(0, 255);
            pb[i] = $urandom_range(0, 255);
        end
        while ((sent < 8 || sb.size() != 0) && cyc < 100) begin
            if (sent < 8) drive(1'b1, 1'b0, md[sent], pr[sent], pg[sent], pb[sent]);
            else drive(1'b0, 1'b0, 0, 0, 0, 0);
            m_ready = !(cyc >= 4 && cyc < 9);
            @(negedge clk);
            if (!m_ready) begin
                n_chk++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready cyc %0d got %b want 0", cyc, s_ready); else n_pass++;
                if (cyc == 4) hold = {m_valid, m_sof, m_r, m_g, m_b};
                else begin
                    n_chk++;
                    if ({m_valid, m_sof, m_r, m_g, m_b} !== hold) $display("FAIL bp_hold cyc %0d got %h want %h", cyc, {m_valid, m_sof, m_r, m_g, m_b}, hold);
                    else n_pass++;
                end
            end
            if (m_valid && m_ready) begin
                n_chk++;
                outs++;
                if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
                if ({m_sof, m_r, m_g, m_b} !== exp) $display("FAIL bp_pixel got %h want %h", {m_sof, m_r, m_g, m_b}, exp);
                else n_pass++;
            end
            if (s_valid && s_ready) begin
                sb.push_back({s_sof, model(mode, s_r, s_g, s_b)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b1;
        n_chk++; if (outs != 8) $display("FAIL bp_count got %0d want 8", outs); else n_pass++;
    endtask

    task automatic test_counter;
        int sofs = 0;
        logic seen = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i >= 7 && i < 10) drive(1'b1, 1'b0, 2, 0, 0, 255);
            else drive(1'b1, (i == 0 || i == 10), 2, 200, 150, 120);
            @(negedge clk);
            if (m_valid && m_ready && m_sof) sofs++;
            @(posedge clk); #1;
            if (sofs == 2 && !seen) begin
                seen = 1'b1;
                n_chk++; if (skin_cnt !== 20'd7) $display("FAIL cnt_frame_a got %0d want 7", skin_cnt); else n_pass++;
            end
        end
        n_chk++; if (!seen) $display("FAIL cnt_sof_seen got %0d sof outputs want 2", sofs); else n_pass++;
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        n_chk++; if (m_valid !== 1'b1) $display("FAIL cnt_mid_valid got %b want 1", m_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL cnt_rst_valid got %b want 0", m_valid); else n_pass++;
        n_chk++; if (skin_cnt !== 20'd0) $display("FAIL cnt_rst_skin got %0d want 0", skin_cnt); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL cnt_discard got %b want 0", m_valid); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_pass;
        test_gray;
        test_skin;
        test_invert;
        test_back_to_back;
        test_backpressure;
        test_counter;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_process_pipe.md
Name: pixel_process_pipe

Overview:
Streaming per-pixel RGB processor with valid/ready handshake and a 3-stage pipeline.
It supersedes the combinational pass-through pixel stage and is inserted between the video source and the output formatter.
Runtime mode selects one of four operations: pass-through, grayscale (luma), skin-mask binarisation (YCbCr window) or invert.
A per-frame skin-pixel counter is provided for downstream tracking logic.

Parameters:
DATA_W, 8, bits per colour channel (legal range 6..12)
CNT_W, 20, width of skin_cnt
CB_MIN_DEF, 76, reset value of the Cb lower bound (exclusive)
CB_MAX_DEF, 128, reset value of the Cb upper bound (exclusive)
CR_MIN_DEF, 132, reset value of the Cr lower bound (exclusive)
CR_MAX_DEF, 174, reset value of the Cr upper bound (exclusive)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  0 pass, 1 gray, 2 skin mask, 3 invert; sampled with each accepted pixel
thr_we  in  1  on a high cycle, load the four threshold registers from thr_*
thr_cb_min, thr_cb_max, thr_cr_min, thr_cr_max  in  DATA_W each  threshold values
s_valid  in  1  input pixel valid
s_ready  out  1  input accept
s_sof  in  1  first pixel of a frame
s_r, s_g, s_b  in  DATA_W each  input channels
m_valid  out  1  output pixel valid
m_ready  in  1  downstream accept
m_sof  out  1  s_sof delayed with its pixel
m_r, m_g, m_b  out  DATA_W each  output channels
skin_cnt  out  CNT_W  mask-white pixel count of the previous complete frame

Behaviour:
- Reset: all pipeline valid bits = 0; m_valid = 0; m_sof = 0; m_r/g/b = 0; skin_cnt = 0; running counter = 0; thresholds = *_DEF.
- Pipeline: one global enable, en = !m_valid || m_ready. s_ready = en.
  - A transfer happens on s_valid && s_ready.
  - When en = 1 every stage advances, and bubbles advance as invalid stages.
  - When en = 0 every stage holds, and all outputs stay stable.
- Latency is exactly 3 cycles from accept to m_valid when there is no stall.
- Mode and sof travel in the pipeline with their pixel. A mode change never affects pixels already accepted.
- Stage 1, multiply:
  - pR = 77R, pG = 150G, pB = 29B for Y.
  - Products for Cb use (-43, -85, +128).
  - Products for Cr use (+128, -107, -21).
  - Intermediate width is DATA_W + 10, signed.
- Stage 2, sum and scale:
  - OFF = 1 << (DATA_W+7).
  - Y = (sumY + 128) >> 8.
  - Cb = (sumCb + OFF + 128) >> 8.
  - Cr = (sumCr + OFF + 128) >> 8.
  - Each of Y, Cb, Cr is clamped to [0, 2^DATA_W - 1].
- Stage 3, select:
  - mode 0: output = input RGB, carried through the pipeline.
  - mode 1: R = G = B = Y.
  - mode 2: white (all ones on all channels) if cb_min < Cb < cb_max and cr_min < Cr < cr_max; otherwise 0. All comparisons are strict and unsigned.
  - mode 3: each channel = ~channel.
- Thresholds: thr_we updates the registers on the next edge. Only stage 2 comparisons made after that edge use the new values. The threshold registers are shared by all pixels in flight.
- skin_cnt, updated on output transfers (m_valid && m_ready):
  - If m_sof = 1: skin_cnt <= running count; running count <= (pixel is mode-2 white ? 1 : 0).
  - Otherwise, running count increments on each mode-2 white pixel.
  - The running count saturates at 2^CNT_W - 1 and does not wrap.
- Simultaneous thr_we and an in-flight pixel: the update edge decides which thresholds apply. No glitch on outputs.
- Reset asserted mid-stream: everything returns to its reset values immediately. Partial frames are discarded.

Decomposition:
- Package pixel_process_pkg holds:
  - mode encodings (MODE_PASS, MODE_GRAY, MODE_SKIN, MODE_INV);
  - the nine YCbCr coefficient constants and the rounding constant 128;
  - the default threshold values.
- One sub-module, rgb2ycbcr_pipe: stages 1-2, parametrised by DATA_W, with a pipeline enable input. It replaces the old combinational converter.

Test Plan:
- Pass-through, mode 0, (10,20,30), m_ready = 1 -> (10,20,30) with m_valid on cycle 3 after accept; s_ready stays high.
- Gray, mode 1, (100,150,200) -> (141,141,141). Input (255,255,255) -> (255,255,255), which checks there is no overflow.
- Skin, mode 2, defaults:
  - (200,150,120) gives Cb = 105, Cr = 155 -> (255,255,255).
  - (0,0,255) gives Cb clamped to 255 -> (0,0,0).
  - After thr_we sets cb_max = 100, the first pixel -> (0,0,0).
- Invert, mode 3, (10,20,30) -> (245,235,225). Then switch mode every pixel: each output matches the mode that was captured with its own pixel.
- Backpressure: feed 8 pixels, hold m_ready = 0 for 5 cycles mid-stream -> s_ready low, outputs held stable, no pixel lost or duplicated, order preserved.
- Counter: frame A has 7 skin pixels, then s_sof starts frame B -> skin_cnt = 7 after the sof pixel's output transfer. Asserting rst_n = 0 mid-frame -> skin_cnt = 0 and m_valid = 0 immediately.
